// File: rtl/freq_gate_counter_pkg.sv
// Shared types and defaults for the frequency gate counter.
// Holds the FSM state enum, default parameters and width helper.
package freq_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    MEASURE   = 2'd2
  } fsm_e;

  localparam int GATE_CYCLES_DEF   = 54000;
  localparam int CNT_W_DEF         = 16;
  localparam int SETTLE_CYCLES_DEF = 1024;
  localparam int SYNC_STAGES_DEF   = 2;

  // Counter width able to hold 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/freq_gate_counter_bit_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Flops clear on async active-low reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/freq_gate_counter.sv
// Gated edge counter measuring sig_in frequency per clk window.
// FREQ_GATE_COUNTER_AVG_EN: publish a 4-window moving average.
module freq_gate_counter
  import freq_meas_pkg::*;
#(
  parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             sig_in,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             measuring
);

  localparam int GW = cnt_width(GATE_CYCLES);
  localparam int SW = cnt_width(SETTLE_CYCLES);

  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);

  logic sig_s;
  logic lock_s;
  logic sig_d1_q;
  logic edge_p;

  fsm_e state_q;
  fsm_e state_d;

  logic [GW-1:0]    gate_q;
  logic [GW-1:0]    gate_d;
  logic [SW-1:0]    settle_q;
  logic [SW-1:0]    settle_d;
  logic [CNT_W-1:0] edge_q;
  logic [CNT_W-1:0] edge_d;
  logic [CNT_W-1:0] data_q;
  logic [CNT_W-1:0] data_d;
  logic             valid_q;
  logic             valid_d;
  logic             ovr_q;
  logic             ovr_d;

  logic [CNT_W-1:0] edge_inc;
  logic [CNT_W-1:0] result;
  logic             win_end;
  logic             publish;
  logic             accept;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_sig (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (sig_in),
    .q_o   (sig_s)
  );

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_lock (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign edge_p = sig_s & ~sig_d1_q;

  assign edge_inc =
    (edge_p && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;

  assign win_end = (state_q == MEASURE) && lock_s &&
                   (gate_q == GATE_LAST);

  assign accept = valid_q && out_ready;

`ifdef FREQ_GATE_COUNTER_AVG_EN
  logic [CNT_W-1:0] h0_q;
  logic [CNT_W-1:0] h1_q;
  logic [CNT_W-1:0] h2_q;
  logic [1:0]       hcnt_q;
  logic [CNT_W+1:0] sum;

  assign sum = {2'b00, edge_inc} + {2'b00, h0_q} +
               {2'b00, h1_q} + {2'b00, h2_q};
  assign result  = CNT_W'(sum >> 2);
  assign publish = win_end && (hcnt_q == 2'd3);

  // Window history; emptied whenever measurement is not running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0_q   <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      hcnt_q <= '0;
    end else if (state_q != MEASURE || !lock_s) begin
      h0_q   <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      hcnt_q <= '0;
    end else if (win_end) begin
      h0_q <= edge_inc;
      h1_q <= h0_q;
      h2_q <= h1_q;
      if (hcnt_q != 2'd3) hcnt_q <= hcnt_q + 1'b1;
    end
  end
`else
  assign result  = edge_inc;
  assign publish = win_end;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: lock loss wins from any state.
  always_comb begin
    state_d = state_q;
    if (!lock_s) begin
      state_d = WAIT_LOCK;
    end else begin
      unique case (state_q)
        WAIT_LOCK: state_d = SETTLE;
        SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = MEASURE;
        end
        MEASURE:   state_d = MEASURE;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Counter and result next-state; lock loss drops the result flags.
  always_comb begin
    gate_d   = '0;
    edge_d   = '0;
    settle_d = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (state_q == SETTLE) begin
      settle_d = settle_q + 1'b1;
    end
    if (state_q == MEASURE) begin
      gate_d = win_end ? '0 : gate_q + 1'b1;
      edge_d = win_end ? '0 : edge_inc;
    end
    if (accept) begin
      valid_d = 1'b0;
    end
    if (publish) begin
      data_d  = result;
      valid_d = 1'b1;
      if (valid_q && !out_ready) ovr_d = 1'b1;
    end
    if (!lock_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_d1_q <= 1'b0;
      gate_q   <= '0;
      edge_q   <= '0;
      settle_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sig_d1_q <= sig_s;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      settle_q <= settle_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign measuring = (state_q == MEASURE);

endmodule
